debug_uart_dump: RTL and testbench

Debug-port reader for the RV32 core. It walks `debug_addr` through the core's debug window: 0–31 are register-file entries, and 32–63 are Test_signal pipeline probes, selected by `debug_addr[5]`. For each address it samples `debug_data` and streams the address/value pair out over a UART 8N1 transmit line. It sits outside the core on the board top level, beside `debug_clk`, and runs on the undivided main clock so a dump is possible while the core is halted in debug mode.

---
 rtl/debug_uart_dump.sv | 122 ++++++++++++
 tb/tb_debug_uart_dump.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_dump.sv
// Walks the core debug window and streams each address/value pair out as
// five UART 8N1 bytes: {0,addr}, data[31:24], data[23:16], data[15:8], data[7:0].
module debug_uart_dump #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned ADDR_LAST = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned     BaudW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);
  localparam logic [6:0]      AddrLast = 7'(ADDR_LAST);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSend,
    StDone
  } state_e;

  state_e            state_q;
  logic [31:0]       word_q;
  logic [BaudW-1:0]  baud_q;
  logic [3:0]        bit_q;
  logic [2:0]        byte_q;

  logic [7:0]        tx_byte;
  logic              next_bit;

  // Byte currently on the wire and the level of the bit that follows bit_q.
  always_comb begin
    tx_byte = '0;
    case (byte_q)
      3'd0:    tx_byte = {1'b0, debug_addr};
      3'd1:    tx_byte = word_q[31:24];
      3'd2:    tx_byte = word_q[23:16];
      3'd3:    tx_byte = word_q[15:8];
      3'd4:    tx_byte = word_q[7:0];
      default: tx_byte = '0;
    endcase
    next_bit = (bit_q == 4'd8) ? 1'b1 : tx_byte[bit_q[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      debug_addr <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_q     <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd <= 1'b1;
          if (start) begin
            state_q    <= StSettle;
            debug_addr <= '0;
            busy       <= 1'b1;
          end
        end

        // debug_addr has had one full cycle through the core mux by now.
        StSettle: begin
          word_q  <= debug_data;
          txd     <= 1'b0;
          baud_q  <= '0;
          bit_q   <= '0;
          byte_q  <= '0;
          state_q <= StSend;
        end

        StSend: begin
          if (baud_q == BaudMax) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
              bit_q <= '0;
              if (byte_q == 3'd4) begin
                txd <= 1'b1;
                if (debug_addr == AddrLast) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                end else begin
                  debug_addr <= debug_addr + 7'd1;
                  state_q    <= StSettle;
                end
              end else begin
                byte_q <= byte_q + 3'd1;
                txd    <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              txd   <= next_bit;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StDone: begin
          txd     <= 1'b1;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_dump.sv
// Bench for debug_uart_dump: two instances (2-entry and 64-entry windows) decoded
// by a behavioural UART receiver and compared with byte streams built from a data table.
module tb_debug_uart_dump;

  localparam int D = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, txd_a, busy_a, done_a;
  logic        rst_b, start_b, txd_b, busy_b, done_b;
  logic [6:0]  addr_a, addr_b;
  logic [31:0] dd_a, dd_b;
  logic [31:0] val_a [2];
  logic [31:0] mem_b [128];

  assign dd_a = (addr_a == 7'd0) ? val_a[0] : val_a[1];
  assign dd_b = mem_b[addr_b];

  debug_uart_dump #(.CLK_DIV(D), .ADDR_LAST(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .debug_addr(addr_a),
    .debug_data(dd_a), .txd(txd_a), .busy(busy_a), .done(done_a)
  );

  debug_uart_dump #(.CLK_DIV(D), .ADDR_LAST(63)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .debug_addr(addr_b),
    .debug_data(dd_b), .txd(txd_b), .busy(busy_b), .done(done_b)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART receiver plus busy/done counters, one lane per DUT.
  bit         dec_act [2];
  int         dec_cnt [2];
  logic [9:0] dec_bits [2];
  logic [9:0] frame0 [2];
  int         glitch [2], framing [2], nframes [2], busy_cnt [2], done_cnt [2];
  logic [7:0] rx_a [$];
  logic [7:0] rx_b [$];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    logic [1:0] tv;
    int         b;
    tv = {txd_b, txd_a};
    if (busy_a) busy_cnt[0]++;
    if (busy_b) busy_cnt[1]++;
    if (done_a) done_cnt[0]++;
    if (done_b) done_cnt[1]++;
    for (int k = 0; k < 2; k++) begin
      if (!dec_act[k]) begin
        if (tv[k] == 1'b0) begin
          dec_act[k]  = 1'b1;
          dec_cnt[k]  = 1;
          dec_bits[k] = '0;
        end
      end else begin
        b = dec_cnt[k] / D;
        if (dec_cnt[k] % D == 0) dec_bits[k][b] = tv[k];
        else if (tv[k] !== dec_bits[k][b]) glitch[k]++;
        dec_cnt[k]++;
        if (dec_cnt[k] == 10 * D) begin
          dec_act[k] = 1'b0;
          if (dec_bits[k][0] !== 1'b0 || dec_bits[k][9] !== 1'b1) framing[k]++;
          if (nframes[k] == 0) frame0[k] = dec_bits[k];
          nframes[k]++;
          if (k == 0) rx_a.push_back(dec_bits[k][8:1]);
          else        rx_b.push_back(dec_bits[k][8:1]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      dec_act[k] = 1'b0; glitch[k] = 0; framing[k] = 0; nframes[k] = 0;
      busy_cnt[k] = 0; done_cnt[k] = 0;
    end
    rx_a.delete();
    rx_b.delete();
    exp_q.delete();
  endtask

  task automatic add_entry(input int addr, input logic [31:0] data);
    exp_q.push_back(8'(addr));
    exp_q.push_back(data[31:24]);
    exp_q.push_back(data[23:16]);
    exp_q.push_back(data[15:8]);
    exp_q.push_back(data[7:0]);
  endtask

  task automatic pulse_start(input int k, output int t0);
    @(negedge clk);
    if (k == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int k, input int budget, output bit seen, output int td);
    seen = 1'b0;
    td   = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((k == 0) ? done_a : done_b) begin
        seen = 1'b1;
        td   = cyc;
      end
    end
  endtask

  task automatic cmp_stream(input string tag, input int k);
    logic [7:0] got [$];
    int         errs;
    if (k == 0) got = rx_a; else got = rx_b;
    chk({tag, "_len"}, got.size(), exp_q.size());
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got.size()) errs++;
      else if (exp_q.size() <= 10) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
      else if (got[i] !== exp_q[i]) errs++;
    end
    chk({tag, "_byte_errs"}, errs, 0);
    chk({tag, "_glitch"}, glitch[k], 0);
    chk({tag, "_framing"}, framing[k], 0);
  endtask

  initial begin
    int         t0, td, errs;
    bit         seen;
    logic [31:0] keep0, keep1;

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    val_a[0] = '0; val_a[1] = '0;
    for (int i = 0; i < 128; i++) mem_b[i] = $urandom;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_txd_a", txd_a, 1);   chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0); chk("rst_addr_a", addr_a, 0);
    chk("rst_txd_b", txd_b, 1);   chk("rst_busy_b", busy_b, 0);
    chk("rst_done_b", done_b, 0); chk("rst_addr_b", addr_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // Two-entry dump with fixed data; bit timing and first frame shape.
    val_a[0] = 32'hDEADBEEF; val_a[1] = 32'h12345678;
    clear_mon();
    add_entry(0, 32'hDEADBEEF); add_entry(1, 32'h12345678);
    pulse_start(0, t0);
    chk("t1_busy_after_e0", busy_a, 1);
    wait_done(0, 600, seen, td);
    chk("t1_done_seen", seen, 1);
    chk("t1_done_latency", td - t0, 402);
    repeat (5) @(negedge clk);
    chk("t1_busy_cycles", busy_cnt[0], 402);
    chk("t1_done_count", done_cnt[0], 1);
    chk("t1_frame0_bits", frame0[0], 10'h200);
    cmp_stream("t1", 0);

    // Latch stability: data changes one cycle after the latch edge.
    keep0 = 32'hDEADBEEF; keep1 = $urandom;
    val_a[0] = keep0; val_a[1] = keep1;
    clear_mon();
    add_entry(0, keep0); add_entry(1, keep1);
    pulse_start(0, t0);
    @(negedge clk);
    val_a[0] = 32'h0;
    wait_done(0, 600, seen, td);
    chk("t2_done_seen", seen, 1);
    repeat (5) @(negedge clk);
    cmp_stream("t2", 0);

    // Start while busy and during the DONE cycle.
    keep0 = $urandom; keep1 = $urandom;
    val_a[0] = keep0; val_a[1] = keep1;
    clear_mon();
    add_entry(0, keep0); add_entry(1, keep1);
    pulse_start(0, t0);
    repeat (150) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 600, seen, td);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("t3_done_seen", seen, 1);
    chk("t3_done_latency", td - t0, 402);
    chk("t3_done_count", done_cnt[0], 1);
    chk("t3_busy_cycles", busy_cnt[0], 402);
    chk("t3_idle_after", busy_a, 0);
    cmp_stream("t3", 0);

    // Reset during data bit 3 of byte 2, then a full dump from address 0.
    keep0 = $urandom; keep1 = $urandom;
    val_a[0] = keep0; val_a[1] = keep1;
    clear_mon();
    pulse_start(0, t0);
    repeat (97) @(negedge clk);
    chk("t4_bit3_byte2", txd_a, keep0[19]);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("t4_rst_txd", txd_a, 1);
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_addr", addr_a, 0);
    rst_a = 1'b0;
    repeat (50) @(negedge clk);
    keep0 = $urandom; keep1 = $urandom;
    val_a[0] = keep0; val_a[1] = keep1;
    clear_mon();
    add_entry(0, keep0); add_entry(1, keep1);
    pulse_start(0, t0);
    wait_done(0, 600, seen, td);
    chk("t4_done_seen", seen, 1);
    chk("t4_done_latency", td - t0, 402);
    repeat (5) @(negedge clk);
    cmp_stream("t4", 0);

    // Full 64-entry window including the Test_signal half.
    clear_mon();
    for (int a = 0; a < 64; a++) add_entry(a, mem_b[a]);
    pulse_start(1, t0);
    wait_done(1, 64 * (1 + 50 * D) + 50, seen, td);
    chk("t5_done_seen", seen, 1);
    chk("t5_done_latency", td - t0, 64 * (1 + 50 * D));
    repeat (40) @(negedge clk);
    chk("t5_done_count", done_cnt[1], 1);
    errs = 0;
    for (int a = 0; a < 64; a++)
      if (5 * a >= rx_b.size() || rx_b[5 * a] !== 8'(a)) errs++;
    chk("t5_addr_seq_errs", errs, 0);
    chk("t5_first_test_signal", (rx_b.size() > 160) ? rx_b[160] : 8'hFF, 8'h20);
    cmp_stream("t5", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
